tff_count_sequencer: RTL and testbench

- Controller that sequences an external bank of WIDTH T flip-flops (shared clk/reset, Q fed back as q_in) as a synchronous up/down counter.
- Each cycle it computes the per-bit toggle vector t_out from the FSM state and the bank's current Q.
- Supports parallel load via toggle-to-target, a programmable limit, continuous (wrap) and one-shot modes, and a terminal-count indication.
- Sits between the user control logic and the T flip-flop bank.

---
 rtl/tff_seq_pkg.sv | 14 +
 rtl/T_Flipflop.sv | 18 +
 rtl/tff_toggle_mask.sv | 24 ++
 rtl/tff_count_sequencer.sv | 128 ++++++++++++
 tb/tb_tff_count_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tff_seq_pkg.sv
// rtl/tff_seq_pkg.sv - shared states and direction constants for the T flip-flop count sequencer
package tff_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/T_Flipflop.sv
// rtl/T_Flipflop.sv - single T flip-flop of the external counter bank
module T_Flipflop (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    // Toggle on t; asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_toggle_mask.sv
// rtl/tff_toggle_mask.sv - carry/borrow toggle vector for one up/down count step of a T flip-flop bank
module tff_toggle_mask
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    output logic [WIDTH-1:0] t
);

    logic chain;

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
    always_comb begin
        chain = 1'b1;
        t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = chain;
            chain = chain & ((dir == DIR_DN) ? ~q[i] : q[i]);
        end
    end

endmodule

// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - sequences an external T flip-flop bank as a loadable up/down counter
module tff_count_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] t_out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic               oneshot_q, oneshot_d;
    logic [WIDTH-1:0]   limit_q, limit_d;

    logic [WIDTH-1:0]   step_mask;
    logic [WIDTH-1:0]   term;
    logic               at_term;

    tff_toggle_mask #(
        .WIDTH (WIDTH)
    ) u_mask (
        .q   (q_in),
        .dir (dir_q),
        .t   (step_mask)
    );

    // Up counts stop/wrap at the limit; down counts stop/wrap at zero.
    assign term    = (dir_q == DIR_DN) ? '0 : limit_q;
    assign at_term = (q_in == term);

    // State and run-configuration registers; configuration only changes on a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            oneshot_q <= 1'b0;
            limit_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            oneshot_q <= oneshot_d;
            limit_q   <= limit_d;
        end
    end

    // Next state, toggle vector and status; load beats stop beats start.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        oneshot_d = oneshot_q;
        limit_d   = limit_q;
        t_out     = '0;
        busy      = 1'b0;
        tc        = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d   = RUN;
                    dir_d     = dir;
                    oneshot_d = oneshot;
                    limit_d   = limit;
                end
            end

            LOAD: begin
                busy    = 1'b1;
                // Toggle exactly the bits that differ so the bank lands on load_val.
                t_out   = q_in ^ load_val;
                state_d = load ? LOAD : IDLE;
            end

            RUN: begin
                busy = 1'b1;
                tc   = at_term;
                if (load) begin
                    state_d = LOAD;
                    t_out   = q_in ^ load_val;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (at_term) begin
                    if (oneshot_q) begin
                        state_d = DONE;
                    end else if (dir_q == DIR_DN) begin
                        t_out = q_in ^ limit_q;
                    end else begin
                        t_out = q_in;
                    end
                end else begin
                    t_out = step_mask;
                end
            end

            DONE: begin
                done = 1'b1;
                if (load) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d   = RUN;
                    dir_d     = dir;
                    oneshot_d = oneshot;
                    limit_d   = limit;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb/tb_tff_count_sequencer.sv - self-checking bench for tff_count_sequencer driving a T flip-flop bank
module tb_tff_count_sequencer;

    localparam int W = 4;
    localparam logic [1:0] MI = 2'd0;
    localparam logic [1:0] ML = 2'd1;
    localparam logic [1:0] MR = 2'd2;
    localparam logic [1:0] MD = 2'd3;

    logic         clk;
    logic         reset;
    logic         start, stop, load, dir, oneshot;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] q, t_out;
    logic         busy, tc, done;

    int checks = 0;
    int errors = 0;

    tff_count_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .oneshot  (oneshot),
        .limit    (limit),
        .q_in     (q),
        .t_out    (t_out),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bank
            T_Flipflop u_tff (
                .clk   (clk),
                .reset (reset),
                .t     (t_out[gi]),
                .q     (q[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] t;
        logic         busy;
        logic         tc;
        logic         done;
        logic [1:0]   mode;
        logic [W-1:0] nq;
        logic         latch;
    } exp_t;

    // Reference: decide what the counter value must be next cycle, then the
    // toggle vector is simply the XOR between now and next.
    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] cq,
                                   input logic ldir, input logic losh, input logic [W-1:0] llim,
                                   input logic i_load, input logic i_stop, input logic i_start,
                                   input logic [W-1:0] i_lv);
        exp_t e;
        logic [W-1:0] trm;
        e.mode  = m;
        e.nq    = cq;
        e.busy  = 1'b0;
        e.tc    = 1'b0;
        e.done  = 1'b0;
        e.latch = 1'b0;
        trm     = ldir ? '0 : llim;
        case (m)
            MI: begin
                if (i_load) e.mode = ML;
                else if (i_start) begin e.mode = MR; e.latch = 1'b1; end
            end
            ML: begin
                e.busy = 1'b1;
                e.nq   = i_lv;
                e.mode = i_load ? ML : MI;
            end
            MR: begin
                e.busy = 1'b1;
                e.tc   = (cq == trm);
                if (i_load) begin
                    e.mode = ML;
                    e.nq   = i_lv;
                end else if (i_stop) begin
                    e.mode = MI;
                end else if (cq == trm) begin
                    if (losh) e.mode = MD;
                    else      e.nq = ldir ? llim : '0;
                end else begin
                    e.nq = ldir ? W'(cq - 1) : W'(cq + 1);
                end
            end
            default: begin
                e.done = 1'b1;
                if (i_load) e.mode = ML;
                else if (i_start) begin e.mode = MR; e.latch = 1'b1; end
            end
        endcase
        e.t = cq ^ e.nq;
        return e;
    endfunction

    logic [1:0]   mm;
    logic [W-1:0] mq, mlim;
    logic         mdir, mosh;
    exp_t         cur;

    assign cur = model(mm, mq, mdir, mosh, mlim, load, stop, start, load_val);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mm   <= MI;
            mq   <= '0;
            mdir <= 1'b0;
            mosh <= 1'b0;
            mlim <= '0;
        end else begin
            mm <= cur.mode;
            mq <= cur.nq;
            if (cur.latch) begin
                mdir <= dir;
                mosh <= oneshot;
                mlim <= limit;
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        chk("model_t_out", t_out, cur.t);
        chk("model_busy", W'(busy), W'(cur.busy));
        chk("model_tc", W'(tc), W'(cur.tc));
        chk("model_done", W'(done), W'(cur.done));
        chk("model_q", q, mq);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        tick();
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic start_run(input logic d, input logic o, input logic [W-1:0] l);
        start = 1'b1; dir = d; oneshot = o; limit = l;
        tick();
        start = 1'b0;
    endtask

    logic [W-1:0] up_seq [8];
    logic [W-1:0] lat_seq [11];

    initial begin
        reset = 1'b1; start = 0; stop = 0; load = 0; dir = 0; oneshot = 0;
        load_val = '0; limit = '0;
        #1;
        chk("rst_t_out", t_out, 4'h0);
        chk("rst_busy", W'(busy), 4'h0);
        chk("rst_tc", W'(tc), 4'h0);
        chk("rst_done", W'(done), 4'h0);
        #21 reset = 1'b0;

        // Load 3, then load A: toggle vector 9 for one cycle.
        do_load(4'h3);
        chk("pre_load_q", q, 4'h3);
        load = 1'b1; load_val = 4'hA;
        tick();
        load = 1'b0;
        #1;
        chk("load_t_out", t_out, 4'h9);
        chk("load_busy", W'(busy), 4'h1);
        tick(); #1;
        chk("load_q", q, 4'hA);
        chk("load_idle_busy", W'(busy), 4'h0);

        // Up wrap with limit 5.
        up_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        do_load(4'h0);
        start_run(1'b0, 1'b0, 4'd5);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("upw_q", q, up_seq[k]);
            chk("upw_tc", W'(tc), W'(up_seq[k] == 4'd5));
            chk("upw_done", W'(done), 4'h0);
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;

        // Down one-shot from 3.
        do_load(4'h3);
        start_run(1'b1, 1'b1, 4'd9);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("dn_q", q, W'(3 - k));
            chk("dn_tc", W'(tc), W'(k == 3));
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("dn_done", W'(done), 4'h1);
            chk("dn_hold_t", t_out, 4'h0);
            chk("dn_hold_q", q, 4'h0);
            tick();
        end

        // Stop and load together at Q=4: load wins.
        do_load(4'h0);
        start_run(1'b0, 1'b0, 4'd9);
        for (int k = 0; k < 4; k++) tick();
        stop = 1'b1; load = 1'b1; load_val = 4'hC;
        #1;
        chk("col_q_pre", q, 4'h4);
        chk("col_t_out", t_out, 4'h8);
        tick();
        stop = 1'b0; load = 1'b0;
        #1;
        chk("col_q", q, 4'hC);
        chk("col_busy_load", W'(busy), 4'h1);
        tick(); #1;
        chk("col_idle", W'(busy), 4'h0);
        chk("col_q_hold", q, 4'hC);

        // Configuration changes mid-run are ignored.
        lat_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2};
        do_load(4'h0);
        start_run(1'b0, 1'b0, 4'd7);
        for (int k = 0; k < 11; k++) begin
            if (k == 3) begin dir = 1'b1; limit = 4'd2; end
            #1;
            chk("lat_q", q, lat_seq[k]);
            chk("lat_tc", W'(tc), W'(lat_seq[k] == 4'd7));
            tick();
        end
        stop = 1'b1; dir = 1'b0; tick(); stop = 1'b0;

        // Asynchronous reset in RUN at Q=6.
        do_load(4'h0);
        start_run(1'b0, 1'b0, 4'd9);
        for (int k = 0; k < 6; k++) tick();
        #1;
        chk("ar_q_pre", q, 4'h6);
        reset = 1'b1;
        #1;
        chk("ar_t_out", t_out, 4'h0);
        chk("ar_busy", W'(busy), 4'h0);
        chk("ar_tc", W'(tc), 4'h0);
        chk("ar_done", W'(done), 4'h0);
        chk("ar_q", q, 4'h0);
        #10 reset = 1'b0;
        tick(); #1;
        chk("ar_post_busy", W'(busy), 4'h0);
        chk("ar_post_q", q, 4'h0);

        // Randomized traffic, checked every cycle by the reference.
        for (int n = 0; n < 600; n++) begin
            tick();
            load     = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 11) == 0);
            start    = ($urandom_range(0, 3) == 0);
            dir      = 1'($urandom_range(0, 1));
            oneshot  = 1'($urandom_range(0, 1));
            limit    = W'($urandom_range(0, 15));
            load_val = W'($urandom_range(0, 15));
        end
        tick();
        load = 0; stop = 0; start = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
